// File: rtl/tabla_pkg.sv
// Shared definitions for the tabla peer FSM and its driver.
// Contents: state width, state codes S0..S5, per-state {n,m} output codes,
// and the driver control-state type.
package tabla_pkg;

    localparam int unsigned STATE_W = 3;
    localparam int unsigned CNT_W   = 8;
    localparam int unsigned STEP_W  = 3;

    typedef logic [STATE_W-1:0] state_t;

    localparam state_t S0 = 3'd0;
    localparam state_t S1 = 3'd1;
    localparam state_t S2 = 3'd2;
    localparam state_t S3 = 3'd3;
    localparam state_t S4 = 3'd4;
    localparam state_t S5 = 3'd5;

    // Moore output codes {n,m} per state
    localparam logic [1:0] NM_S0 = 2'b10;
    localparam logic [1:0] NM_S1 = 2'b00;
    localparam logic [1:0] NM_S2 = 2'b11;
    localparam logic [1:0] NM_S3 = 2'b10;
    localparam logic [1:0] NM_S4 = 2'b01;
    localparam logic [1:0] NM_S5 = 2'b00;

    typedef enum logic {
        CTRL_IDLE = 1'b0,
        CTRL_BUSY = 1'b1
    } ctrl_t;

endpackage

// File: rtl/tabla_model.sv
// Combinational next-state and Moore output function of the tabla peer.
// Ports: state (current), a/b (peer inputs) -> next_state, nm ({n,m}).
module tabla_model
    import tabla_pkg::*;
(
    input  state_t     state,
    input  logic       a,
    input  logic       b,
    output state_t     next_state,
    output logic [1:0] nm
);

    always_comb begin
        next_state = S0;
        nm         = 2'b00;
        case (state)
            S0: begin
                nm         = NM_S0;
                next_state = a ? S1 : S0;
            end
            S1: begin
                nm         = NM_S1;
                next_state = S2;
            end
            S2: begin
                nm = NM_S2;
                if (~a & b) begin
                    next_state = S3;
                end else if (a & ~b) begin
                    next_state = S4;
                end else begin
                    next_state = S2;
                end
            end
            S3: begin
                nm         = NM_S3;
                next_state = (a & b) ? S0 : S3;
            end
            S4: begin
                nm         = NM_S4;
                next_state = b ? S3 : S5;
            end
            S5: begin
                nm         = NM_S5;
                next_state = S0;
            end
            default: begin
                nm         = 2'b00;
                next_state = S0;
            end
        endcase
    end

endmodule

// File: rtl/tabla_driver.sv
// Active driver for the tabla peer FSM: accepts a target-state request,
// steers a/b along the shortest path, shadows the peer state and checks
// the peer's {n,m} against the shadow every cycle.
// Ports: clk, rst_b (async active-low); req_valid/req_target/req_ready
// request handshake; a/b drive to peer; n/m peer outputs; done/steps
// completion; bad_req rejected target; err/err_cnt output mismatch.
module tabla_driver
    import tabla_pkg::*;
(
    input  logic              clk,
    input  logic              rst_b,
    input  logic              req_valid,
    input  logic [2:0]        req_target,
    output logic              req_ready,
    output logic              a,
    output logic              b,
    input  logic              n,
    input  logic              m,
    output logic              done,
    output logic              bad_req,
    output logic [STEP_W-1:0] steps,
    output logic              err,
    output logic [CNT_W-1:0]  err_cnt
);

    ctrl_t             ctrl_q;
    ctrl_t             ctrl_d;
    state_t            shadow;
    state_t            shadow_nx;
    state_t            target;
    logic [STEP_W-1:0] step_cnt;
    logic [1:0]        shadow_nm;
    logic [1:0]        ab_c;
    logic              busy;
    logic              accept;
    logic              target_ok;
    logic              hit;
    logic              mismatch;

    assign busy      = (ctrl_q == CTRL_BUSY);
    assign accept    = req_valid & req_ready;
    assign target_ok = (state_t'(req_target) <= S5);
    assign hit       = busy & (shadow == target);
    assign mismatch  = ({n, m} != shadow_nm);

    // Same transition function as the peer, evaluated on what we drive
    tabla_model u_model (
        .state      (shadow),
        .a          (ab_c[1]),
        .b          (ab_c[0]),
        .next_state (shadow_nx),
        .nm         (shadow_nm)
    );

    // Control state register
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            ctrl_q <= CTRL_IDLE;
        end else begin
            ctrl_q <= ctrl_d;
        end
    end

    // Control next-state
    always_comb begin
        ctrl_d = ctrl_q;
        case (ctrl_q)
            CTRL_IDLE: if (accept && target_ok) ctrl_d = CTRL_BUSY;
            CTRL_BUSY: if (hit)                 ctrl_d = CTRL_IDLE;
            default:                            ctrl_d = CTRL_IDLE;
        endcase
    end

    // Control outputs: shortest-path routing while busy, 00 when idle
    always_comb begin
        ab_c      = 2'b00;
        req_ready = (ctrl_q == CTRL_IDLE);
        if (ctrl_q == CTRL_BUSY) begin
            case (shadow)
                S0:      ab_c = (target == S0) ? 2'b00 : 2'b10;
                S1:      ab_c = 2'b00;
                S2: begin
                    if (target == S2) begin
                        ab_c = 2'b00;
                    end else if (target == S4 || target == S5) begin
                        ab_c = 2'b10;
                    end else begin
                        ab_c = 2'b01;
                    end
                end
                S3:      ab_c = (target == S3) ? 2'b00 : 2'b11;
                S4:      ab_c = (target == S3) ? 2'b01 : 2'b00;
                default: ab_c = 2'b00;
            endcase
        end
    end

    assign a = ab_c[1];
    assign b = ab_c[0];

    // Shadow, request latch, step counter and completion reporting
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            shadow   <= S0;
            target   <= S0;
            step_cnt <= '0;
            steps    <= '0;
            done     <= 1'b0;
            bad_req  <= 1'b0;
        end else begin
            // Shadow follows every edge, including idle and completion edges
            shadow  <= shadow_nx;
            done    <= hit;
            bad_req <= accept & ~target_ok;
            if (accept && target_ok) begin
                target   <= state_t'(req_target);
                step_cnt <= '0;
            end else if (busy && !hit) begin
                step_cnt <= step_cnt + STEP_W'(1);
            end
            if (hit) begin
                steps <= step_cnt;
            end
        end
    end

    // Output checker with saturating mismatch counter
    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            err     <= 1'b0;
            err_cnt <= '0;
        end else begin
            err <= mismatch;
            if (mismatch && (err_cnt != {CNT_W{1'b1}})) begin
                err_cnt <= err_cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_tabla_driver.sv
// Directed bench for tabla_driver with a behavioural peer FSM and a
// scoreboard of expected step counts.
module tb_tabla_driver;

    logic       clk;
    logic       rst_b;
    logic       req_valid;
    logic [2:0] req_target;
    logic       req_ready;
    logic       a;
    logic       b;
    logic       n;
    logic       m;
    logic       done;
    logic       bad_req;
    logic [2:0] steps;
    logic       err;
    logic [7:0] err_cnt;

    logic [2:0] p_state;
    logic       m_stuck;
    int         exp_q[$];
    int         n_total;
    int         n_pass;

    tabla_driver dut (
        .clk        (clk),
        .rst_b      (rst_b),
        .req_valid  (req_valid),
        .req_target (req_target),
        .req_ready  (req_ready),
        .a          (a),
        .b          (b),
        .n          (n),
        .m          (m),
        .done       (done),
        .bad_req    (bad_req),
        .steps      (steps),
        .err        (err),
        .err_cnt    (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural peer
    function automatic logic [2:0] peer_next(input logic [2:0] s, input logic ia, input logic ib);
        case (s)
            3'd0:    return ia ? 3'd1 : 3'd0;
            3'd1:    return 3'd2;
            3'd2:    return (!ia && ib) ? 3'd3 : ((ia && !ib) ? 3'd4 : 3'd2);
            3'd3:    return (ia && ib) ? 3'd0 : 3'd3;
            3'd4:    return ib ? 3'd3 : 3'd5;
            3'd5:    return 3'd0;
            default: return 3'd0;
        endcase
    endfunction

    function automatic logic [1:0] peer_out(input logic [2:0] s);
        case (s)
            3'd0:    return 2'b10;
            3'd2:    return 2'b11;
            3'd3:    return 2'b10;
            3'd4:    return 2'b01;
            default: return 2'b00;
        endcase
    endfunction

    // Expected routing {a,b} toward target
    function automatic logic [1:0] ref_route(input logic [2:0] s, input logic [2:0] t);
        case (s)
            3'd0:    return (t == 3'd0) ? 2'b00 : 2'b10;
            3'd2:    return (t == 3'd2) ? 2'b00 : ((t >= 3'd4) ? 2'b10 : 2'b01);
            3'd3:    return (t == 3'd3) ? 2'b00 : 2'b11;
            3'd4:    return (t == 3'd3) ? 2'b01 : 2'b00;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int path_len(input logic [2:0] start, input logic [2:0] t);
        logic [2:0] s;
        logic [1:0] ab;
        int         len;
        s   = start;
        len = 0;
        while (s != t && len < 8) begin
            ab  = ref_route(s, t);
            s   = peer_next(s, ab[1], ab[0]);
            len = len + 1;
        end
        return len;
    endfunction

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) p_state <= 3'd0;
        else        p_state <= peer_next(p_state, a, b);
    end

    assign n = peer_out(p_state)[1];
    assign m = peer_out(p_state)[0] | m_stuck;

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Call at a negedge while idle; returns 1ns after the acceptance edge
    task automatic issue_req(input logic [2:0] t);
        req_valid  = 1'b1;
        req_target = t;
        if (t <= 3'd5) begin
            check("ready_before_req", 8'(req_ready), 8'd1);
            exp_q.push_back(path_len(peer_next(p_state, 1'b0, 1'b0), t));
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen;
        int e;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1'b1;
        end
        check({tag, "_done"}, 8'(seen), 8'd1);
        if (seen && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check({tag, "_steps"}, 8'(steps), 8'(e));
        end
    endtask

    initial begin
        int cnt;
        n_total    = 0;
        n_pass     = 0;
        rst_b      = 1'b0;
        req_valid  = 1'b0;
        req_target = 3'd0;
        m_stuck    = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_ready", 8'(req_ready), 8'd1);
        check("rst_ab", 8'({a, b}), 8'd0);
        check("rst_done", 8'(done), 8'd0);
        check("rst_steps", 8'(steps), 8'd0);
        check("rst_err", 8'(err), 8'd0);
        check("rst_err_cnt", err_cnt, 8'd0);
        rst_b = 1'b1;
        repeat (2) @(negedge clk);

        // S0 -> S2
        issue_req(3'd2);
        check("t2_ab_first", 8'({a, b}), 8'b10);
        check("t2_ready_busy", 8'(req_ready), 8'd0);
        @(posedge clk); #1;
        check("t2_ab_second", 8'({a, b}), 8'b00);
        wait_done("t2");
        check("t2_ready_in_done", 8'(req_ready), 8'd1);
        check("t2_err_cnt", err_cnt, 8'd0);

        // S2 -> S0 via S3
        issue_req(3'd0);
        check("t0_ab_first", 8'({a, b}), 8'b01);
        @(posedge clk); #1;
        check("t0_ab_second", 8'({a, b}), 8'b11);
        wait_done("t0");

        // S0 -> S4, then back-to-back request issued in the done cycle
        issue_req(3'd4);
        wait_done("t4");
        issue_req(3'd3);
        wait_done("t3_b2b");

        // Return to S0 (S3 -> S0)
        issue_req(3'd0);
        wait_done("t0_again");

        // Invalid target
        issue_req(3'd6);
        check("bad_ready", 8'(req_ready), 8'd1);
        check("bad_ab", 8'({a, b}), 8'd0);
        @(negedge clk);
        check("bad_pulse", 8'(bad_req), 8'd1);
        check("bad_no_done", 8'(done), 8'd0);
        @(negedge clk);
        check("bad_pulse_end", 8'(bad_req), 8'd0);
        check("bad_no_err", err_cnt, 8'd0);

        // m stuck-at-1 for three cycles while holding S0
        m_stuck = 1'b1;
        cnt     = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (err) cnt++;
        end
        m_stuck = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (err) cnt++;
        end
        check("stuck_err_pulses", 8'(cnt), 8'd3);
        check("stuck_err_cnt", err_cnt, 8'd3);

        // Reset during a request to S4
        issue_req(3'd4);
        @(negedge clk);
        rst_b = 1'b0;
        #1;
        void'(exp_q.pop_back());
        check("mid_rst_ready", 8'(req_ready), 8'd1);
        check("mid_rst_ab", 8'({a, b}), 8'd0);
        check("mid_rst_steps", 8'(steps), 8'd0);
        check("mid_rst_err_cnt", err_cnt, 8'd0);
        check("mid_rst_done", 8'(done), 8'd0);
        repeat (2) @(negedge clk);
        rst_b = 1'b1;
        cnt   = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (done) cnt++;
        end
        check("mid_rst_no_done", 8'(cnt), 8'd0);
        check("mid_rst_no_err", err_cnt, 8'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
